// File: rtl/beep_tone_decoder_if.sv
// rtl/beep_tone_decoder_if.sv - beep line in, decoded tone status out
interface beep_tone_decoder_if #(
    parameter int CNT_W = 24
);
    logic             beep_in;
    logic [CNT_W-1:0] period;
    logic             tone_active;
    logic             note_start;
    logic             note_end;
    logic [15:0]      note_periods;

    modport master (
        input  beep_in,
        output period,
        output tone_active,
        output note_start,
        output note_end,
        output note_periods
    );

    modport slave (
        output beep_in,
        input  period,
        input  tone_active,
        input  note_start,
        input  note_end,
        input  note_periods
    );
endinterface

// File: rtl/beep_tone_decoder.sv
// rtl/beep_tone_decoder.sv - square-wave beep period decoder with tone lock and note events
// Optional input glitch filter: define BEEP_DEC_GLITCH_FILTER_EN.
module beep_tone_decoder #(
    parameter int CNT_W       = 24,
    parameter int SILENCE_CYC = 2_000_000,
    parameter int TOL_SHIFT   = 4,
    parameter int MIN_PULSE   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    beep_tone_decoder_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_LOCK1,
        S_TONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] SIL_CNT = CNT_W'(SILENCE_CYC);

    logic             sync1, sync2;
    logic             lvl, lvl_prev, rise;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] diff, tol;
    logic             match, timeout;
    state_t           state, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [15:0]      np_q, np_d;
    logic             start_q, start_d;
    logic             end_q, end_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.beep_in;
            sync2 <= sync1;
        end
    end

`ifdef BEEP_DEC_GLITCH_FILTER_EN
    localparam int HOLD_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;

    logic              lvl_q;
    logic [HOLD_W-1:0] hold;

    // level flips only after sync2 has disagreed with it for MIN_PULSE cycles in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
            hold  <= '0;
        end else if (sync2 == lvl_q) begin
            hold <= '0;
        end else if (hold == HOLD_W'(MIN_PULSE - 1)) begin
            lvl_q <= sync2;
            hold  <= '0;
        end else begin
            hold <= hold + 1'b1;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_prev <= 1'b0;
            rise     <= 1'b0;
        end else begin
            lvl_prev <= lvl;
            rise     <= lvl & ~lvl_prev;
        end
    end

    // cnt is the measured period whenever rise is high
    always_comb begin
        diff    = (cnt >= ref_q) ? (cnt - ref_q) : (ref_q - cnt);
        tol     = ref_q >> TOL_SHIFT;
        match   = (cnt != CNT_MAX) && (diff <= tol);
        timeout = (state != S_IDLE) && !rise && (cnt == SIL_CNT);
    end

    always_comb begin
        state_d  = state;
        ref_d    = ref_q;
        period_d = period_q;
        np_d     = np_q;
        start_d  = 1'b0;
        end_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (rise) begin
                    state_d = S_LOCK1;
                    ref_d   = cnt;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK1: begin
                if (rise) begin
                    ref_d = cnt;
                    if (match) begin
                        state_d  = S_TONE;
                        period_d = cnt;
                        np_d     = 16'd2;
                        start_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_TONE: begin
                if (rise) begin
                    ref_d = cnt;
                    if (match) begin
                        period_d = cnt;
                        np_d     = (np_q == 16'hFFFF) ? np_q : np_q + 16'd1;
                    end else begin
                        state_d = S_LOCK1;
                        end_d   = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    end_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        if (state == S_IDLE || timeout) cnt_d = '0;
        if (rise) cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ref_q    <= '0;
            period_q <= '0;
            np_q     <= '0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            ref_q    <= ref_d;
            period_q <= period_d;
            np_q     <= np_d;
            start_q  <= start_d;
            end_q    <= end_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.tone_active  = (state == S_TONE);
    assign bus.note_start   = start_q;
    assign bus.note_end     = end_q;
    assign bus.note_periods = np_q;

endmodule

// File: tb/tb_beep_tone_decoder.sv
// tb/tb_beep_tone_decoder.sv - directed self-checking bench for beep_tone_decoder
module tb_beep_tone_decoder;

    localparam int CNT_W = 24;
    localparam int SIL   = 3000;
    localparam int TOLS  = 4;
    localparam int MINP  = 8;
`ifdef BEEP_DEC_GLITCH_FILTER_EN
    localparam int FLT    = MINP;
    localparam int GL_END = 0;
`else
    localparam int FLT    = 0;
    localparam int GL_END = 1;
`endif
    localparam int LAT = 4 + FLT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    beep_tone_decoder_if #(.CNT_W(CNT_W)) bus ();

    beep_tone_decoder #(
        .CNT_W      (CNT_W),
        .SILENCE_CYC(SIL),
        .TOL_SHIFT  (TOLS),
        .MIN_PULSE  (MINP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int ns_cnt   = 0;
    int ne_cnt   = 0;
    int both_cnt = 0;
    int ne0;

    always @(negedge clk) begin
        if (bus.note_start) ns_cnt++;
        if (bus.note_end) ne_cnt++;
        if (bus.note_start && bus.note_end) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo);
        bus.beep_in = 1'b1;
        repeat (hi) tick();
        bus.beep_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic gwave();
        bus.beep_in = 1'b1;
        repeat (500) tick();
        bus.beep_in = 1'b0;
        repeat (250) tick();
        bus.beep_in = 1'b1;
        repeat (3) tick();
        bus.beep_in = 1'b0;
        repeat (247) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.beep_in = 1'b0;
        rst_n       = 1'b0;
        repeat (3) tick();
        chk("rst_period", 32'(bus.period), 0);
        chk("rst_tone", 32'(bus.tone_active), 0);
        chk("rst_start", 32'(bus.note_start), 0);
        chk("rst_end", 32'(bus.note_end), 0);
        chk("rst_np", 32'(bus.note_periods), 0);

        rst_n = 1'b1;
        repeat (3 * SIL) tick();
        chk("idle_starts", ns_cnt, 0);
        chk("idle_ends", ne_cnt, 0);
        chk("idle_tone", 32'(bus.tone_active), 0);
        chk("idle_period", 32'(bus.period), 0);

        // lock: third rise of a 1000-cycle tone
        wave(500, 500);
        wave(500, 500);
        bus.beep_in = 1'b1;
        repeat (LAT - 1) tick();
        chk("lock_start_early", 32'(bus.note_start), 0);
        tick();
        chk("lock_start", 32'(bus.note_start), 1);
        chk("lock_period", 32'(bus.period), 1000);
        chk("lock_tone", 32'(bus.tone_active), 1);
        chk("lock_np2", 32'(bus.note_periods), 2);
        repeat (500 - LAT) tick();
        bus.beep_in = 1'b0;
        repeat (500) tick();
        wave(500, 500);
        chk("lock_np3", 32'(bus.note_periods), 3);
        wave(500, 500);
        chk("lock_np4", 32'(bus.note_periods), 4);
        chk("lock_start_once", ns_cnt, 1);

        // tone change to period 2000
        wave(1000, 1000);
        chk("chg_np5", 32'(bus.note_periods), 5);
        bus.beep_in = 1'b1;
        repeat (LAT - 1) tick();
        chk("chg_end_early", 32'(bus.note_end), 0);
        tick();
        chk("chg_end", 32'(bus.note_end), 1);
        chk("chg_tone_off", 32'(bus.tone_active), 0);
        chk("chg_period_hold", 32'(bus.period), 1000);
        repeat (1000 - LAT) tick();
        bus.beep_in = 1'b0;
        repeat (1000) tick();
        bus.beep_in = 1'b1;
        repeat (LAT) tick();
        chk("chg_start", 32'(bus.note_start), 1);
        chk("chg_period", 32'(bus.period), 2000);
        chk("chg_np2", 32'(bus.note_periods), 2);
        repeat (1000 - LAT) tick();
        bus.beep_in = 1'b0;
        repeat (1000) tick();

        // back to 1000, then tolerance window
        ne0 = ne_cnt;
        wave(500, 500);
        wave(500, 500);
        wave(500, 500);
        chk("tol_relock", 32'(bus.tone_active), 1);
        wave(500, 550);
        wave(500, 500);
        wave(500, 550);
        wave(500, 500);
        wave(500, 500);
        chk("tol_keep_ends", ne_cnt, ne0 + 1);
        chk("tol_keep_tone", 32'(bus.tone_active), 1);
        chk("tol_keep_np", 32'(bus.note_periods), 7);
        wave(500, 600);
        wave(500, 500);
        chk("tol_break_ends", ne_cnt, ne0 + 2);
        chk("tol_break_tone", 32'(bus.tone_active), 0);
        chk("tol_break_period", 32'(bus.period), 1000);
        chk("tol_break_np", 32'(bus.note_periods), 8);
        wave(500, 500);
        wave(500, 500);
        chk("tol_recover_tone", 32'(bus.tone_active), 1);
        chk("tol_recover_np", 32'(bus.note_periods), 2);

        // silence after the last rise
        bus.beep_in = 1'b1;
        repeat (500) tick();
        bus.beep_in = 1'b0;
        repeat (SIL + LAT - 500 - 1) tick();
        chk("sil_end_early", 32'(bus.note_end), 0);
        tick();
        chk("sil_end", 32'(bus.note_end), 1);
        chk("sil_tone", 32'(bus.tone_active), 0);
        chk("sil_period", 32'(bus.period), 1000);
        chk("sil_np", 32'(bus.note_periods), 3);
        repeat (100) tick();
        chk("sil_np_hold", 32'(bus.note_periods), 3);
        chk("sil_period_hold", 32'(bus.period), 1000);

        // 3-cycle glitches in the low phase
        wave(500, 500);
        wave(500, 500);
        wave(500, 500);
        chk("gl_lock", 32'(bus.tone_active), 1);
        ne0 = ne_cnt;
        gwave();
        gwave();
        gwave();
        chk("gl_ends", ne_cnt, ne0 + GL_END);
        wave(500, 500);
        wave(500, 500);
        wave(500, 500);
        chk("gl_relock", 32'(bus.tone_active), 1);

        // reset mid-note
        ne0 = ne_cnt;
        bus.beep_in = 1'b1;
        repeat (200) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_period", 32'(bus.period), 0);
        chk("mrst_tone", 32'(bus.tone_active), 0);
        chk("mrst_start", 32'(bus.note_start), 0);
        chk("mrst_end", 32'(bus.note_end), 0);
        chk("mrst_np", 32'(bus.note_periods), 0);
        repeat (5) tick();
        chk("mrst_no_end", ne_cnt, ne0);
        bus.beep_in = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
